iq_phase_frequency_detector: RTL and testbench

Receive-side counterpart of the team's NCO. Takes signed I/Q sample pairs (cosine/sine) on a sample clock-enable and recovers instantaneous phase with an iterative CORDIC in vectoring mode. Also outputs per-sample phase difference, which is the estimated NCO phase increment in the same turn scaling as the NCO accumulator top bits. Sits after the mixer/decimator in the SDR receive chain and feeds FM demodulation and carrier tracking.

---
 rtl/iq_phase_pkg.sv | 41 ++++
 rtl/iq_phase_frequency_detector_cordic.sv | 99 +++++++++
 rtl/iq_phase_frequency_detector.sv | 131 +++++++++++++
 tb/tb_iq_phase_frequency_detector.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iq_phase_pkg.sv
// rtl/iq_phase_pkg.sv - shared constants, ATAN table and FSM state type for the I/Q phase detector
//
// Contents:
//   CORDIC_GAIN_COMP : 1/K CORDIC gain compensation, 0.60725 in Q0.8
//   state_t          : top-level FSM state encoding
//   atan_turns16()   : atan(2^-i) expressed in turns, scaled to 2^16 per turn
package iq_phase_pkg;

  localparam int CORDIC_GAIN_COMP = 155;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // 16-bit turn scaling; callers shift right to reach narrower phase widths.
  function automatic logic [15:0] atan_turns16(input logic [4:0] idx);
    logic [15:0] val;
    case (idx)
      5'd0:    val = 16'd8192;
      5'd1:    val = 16'd4836;
      5'd2:    val = 16'd2555;
      5'd3:    val = 16'd1297;
      5'd4:    val = 16'd651;
      5'd5:    val = 16'd326;
      5'd6:    val = 16'd163;
      5'd7:    val = 16'd81;
      5'd8:    val = 16'd41;
      5'd9:    val = 16'd20;
      5'd10:   val = 16'd10;
      5'd11:   val = 16'd5;
      5'd12:   val = 16'd3;
      5'd13:   val = 16'd1;
      5'd14:   val = 16'd1;
      default: val = 16'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/iq_phase_frequency_detector_cordic.sv
// rtl/iq_phase_frequency_detector_cordic.sv - iterative vectoring-mode CORDIC core
//
// Ports:
//   clk, arst  : clock, asynchronous active-high reset
//   start      : one-cycle pulse, captures i_in/q_in and pre-rotates into the right half-plane
//   i_in, q_in : signed sample
//   x_final    : gain-scaled magnitude in guard-bit units (only with IQ_PHASE_DETECTOR_MAG_EN)
//   z_final    : accumulated angle, one turn = 2^PHASE_WIDTH
//   done       : high during the cycle whose edge performs the last micro-rotation
module cordic_vectoring_core
  import iq_phase_pkg::*;
#(
  parameter int DATA_WIDTH  = 7,
  parameter int PHASE_WIDTH = 16,
  parameter int ITERATIONS  = 12,
  parameter int GUARD_BITS  = 4
) (
  input  logic                                    clk,
  input  logic                                    arst,
  input  logic                                    start,
  input  logic signed [DATA_WIDTH-1:0]            i_in,
  input  logic signed [DATA_WIDTH-1:0]            q_in,
`ifdef IQ_PHASE_DETECTOR_MAG_EN
  output logic signed [DATA_WIDTH+GUARD_BITS+1:0] x_final,
`endif
  output logic        [PHASE_WIDTH-1:0]           z_final,
  output logic                                    done
);

  localparam int XW = DATA_WIDTH + 2 + GUARD_BITS;
  localparam int CW = 5;

  logic signed [XW-1:0]          x;
  logic signed [XW-1:0]          y;
  logic signed [XW-1:0]          i_ext;
  logic signed [XW-1:0]          q_ext;
  logic signed [XW-1:0]          x_shr;
  logic signed [XW-1:0]          y_shr;
  logic        [PHASE_WIDTH-1:0] z;
  logic        [PHASE_WIDTH-1:0] atan_step;
  logic        [15:0]            atan_raw;
  logic        [CW-1:0]          cnt;
  logic                          running;

  // Two integer headroom bits let -2^(DATA_WIDTH-1) be negated and absorb the CORDIC gain.
  assign i_ext = {{2{i_in[DATA_WIDTH-1]}}, i_in, {GUARD_BITS{1'b0}}};
  assign q_ext = {{2{q_in[DATA_WIDTH-1]}}, q_in, {GUARD_BITS{1'b0}}};

  assign x_shr     = x >>> cnt;
  assign y_shr     = y >>> cnt;
  assign atan_raw  = atan_turns16(cnt);
  assign atan_step = PHASE_WIDTH'(atan_raw >> (16 - PHASE_WIDTH));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      x       <= '0;
      y       <= '0;
      z       <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      // Left half-plane samples are rotated by pi so the iterations only span +-pi/2.
      if (i_in[DATA_WIDTH-1]) begin
        x <= -i_ext;
        y <= -q_ext;
        z <= {1'b1, {(PHASE_WIDTH-1){1'b0}}};
      end else begin
        x <= i_ext;
        y <= q_ext;
        z <= '0;
      end
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      if (!y[XW-1]) begin
        x <= x + y_shr;
        y <= y - x_shr;
        z <= z + atan_step;
      end else begin
        x <= x - y_shr;
        y <= y + x_shr;
        z <= z - atan_step;
      end
      if (cnt == CW'(ITERATIONS - 1)) begin
        running <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign done = running && (cnt == CW'(ITERATIONS - 1));

`ifdef IQ_PHASE_DETECTOR_MAG_EN
  assign x_final = x;
`endif
  assign z_final = z;

endmodule

// File: rtl/iq_phase_frequency_detector.sv
// rtl/iq_phase_frequency_detector.sv - I/Q to phase, frequency and magnitude detector
//
// Optional build macro: IQ_PHASE_DETECTOR_MAG_EN (gain-compensated magnitude output).
//
// Ports:
//   clk, arst      : clock, asynchronous active-high reset
//   sample_clk_ce  : one-cycle strobe, i_in/q_in valid
//   i_in, q_in     : signed I/Q sample
//   phase          : atan2(q,i), one turn = 2^PHASE_WIDTH
//   freq           : signed wrapped phase(n) - phase(n-1)
//   magnitude      : |I+jQ| (0 unless IQ_PHASE_DETECTOR_MAG_EN)
//   out_valid      : one-cycle pulse when phase/freq/magnitude update
//   busy           : sample in flight
//   overrun        : sticky, strobe seen while busy
module iq_phase_frequency_detector
  import iq_phase_pkg::*;
#(
  parameter int DATA_WIDTH  = 7,
  parameter int PHASE_WIDTH = 16,
  parameter int ITERATIONS  = 12,
  parameter int GUARD_BITS  = 4
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          sample_clk_ce,
  input  logic signed [DATA_WIDTH-1:0]  i_in,
  input  logic signed [DATA_WIDTH-1:0]  q_in,
  output logic        [PHASE_WIDTH-1:0] phase,
  output logic        [PHASE_WIDTH-1:0] freq,
  output logic        [DATA_WIDTH:0]    magnitude,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          overrun
);

  state_t                 state;
  logic                   core_start;
  logic                   core_done;
  logic [PHASE_WIDTH-1:0] z_final;
  logic [PHASE_WIDTH-1:0] prev_phase;
  logic                   first_flag;
  logic                   zero_sample;
  logic [DATA_WIDTH:0]    mag_next;

  assign core_start = (state == S_IDLE) && sample_clk_ce;
  assign busy       = (state != S_IDLE);

`ifdef IQ_PHASE_DETECTOR_MAG_EN
  localparam int XW = DATA_WIDTH + 2 + GUARD_BITS;
  localparam int MW = XW + 8;
  localparam int SH = 8 + GUARD_BITS;

  logic signed [XW-1:0] x_final;
  logic        [XW-2:0] x_pos;
  logic        [MW-1:0] mag_scaled;

  assign x_pos      = x_final[XW-1] ? '0 : x_final[XW-2:0];
  // Remove CORDIC gain (Q0.8) and the guard bits, rounding to nearest.
  assign mag_scaled = ((MW'(x_pos) * MW'(CORDIC_GAIN_COMP)) + MW'(1 << (SH - 1))) >> SH;
  assign mag_next   = (|mag_scaled[MW-1:DATA_WIDTH+1]) ? '1 : mag_scaled[DATA_WIDTH:0];
`else
  assign mag_next = '0;
`endif

  cordic_vectoring_core #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PHASE_WIDTH (PHASE_WIDTH),
    .ITERATIONS  (ITERATIONS),
    .GUARD_BITS  (GUARD_BITS)
  ) u_core (
    .clk     (clk),
    .arst    (arst),
    .start   (core_start),
    .i_in    (i_in),
    .q_in    (q_in),
`ifdef IQ_PHASE_DETECTOR_MAG_EN
    .x_final (x_final),
`endif
    .z_final (z_final),
    .done    (core_done)
  );

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= S_IDLE;
      phase       <= '0;
      freq        <= '0;
      magnitude   <= '0;
      out_valid   <= 1'b0;
      overrun     <= 1'b0;
      prev_phase  <= '0;
      first_flag  <= 1'b1;
      zero_sample <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (sample_clk_ce && (state != S_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (sample_clk_ce) begin
            zero_sample <= (i_in == '0) && (q_in == '0);
            state       <= S_ITER;
          end
        end
        S_ITER: begin
          if (core_done) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          out_valid <= 1'b1;
          state     <= S_IDLE;
          if (zero_sample) begin
            // Angle is undefined: keep phase and the differencing reference untouched.
            freq      <= '0;
            magnitude <= '0;
          end else begin
            phase      <= z_final;
            freq       <= first_flag ? '0 : (z_final - prev_phase);
            prev_phase <= z_final;
            first_flag <= 1'b0;
            magnitude  <= mag_next;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iq_phase_frequency_detector.sv
// tb/tb_iq_phase_frequency_detector.sv - self-checking bench for iq_phase_frequency_detector
module tb_iq_phase_frequency_detector;

  localparam real PI = 3.14159265358979;
`ifdef IQ_PHASE_DETECTOR_MAG_EN
  localparam int MAG_TOL = 2;
`else
  localparam int MAG_TOL = 0;
`endif

  logic              clk = 1'b0;
  logic              arst = 1'b1;
  logic              sample_clk_ce = 1'b0;
  logic signed [6:0] i_in = '0;
  logic signed [6:0] q_in = '0;
  logic [15:0]       phase;
  logic [15:0]       freq;
  logic [7:0]        magnitude;
  logic              out_valid;
  logic              busy;
  logic              overrun;

  int errors = 0;
  int checks = 0;
  int sched[$];

  typedef struct {
    int i;
    int q;
    int exp_phase;
    int exp_freq;
  } vec_t;

  vec_t vecs[8];

  iq_phase_frequency_detector dut (
    .clk           (clk),
    .arst          (arst),
    .sample_clk_ce (sample_clk_ce),
    .i_in          (i_in),
    .q_in          (q_in),
    .phase         (phase),
    .freq          (freq),
    .magnitude     (magnitude),
    .out_valid     (out_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int wdiff(input int a, input int b);
    int d;
    d = (a - b) & 65535;
    if (d >= 32768) d -= 65536;
    return d;
  endfunction

  function automatic int model_phase(input int i, input int q);
    real a;
    a = $atan2(real'(q), real'(i)) / (2.0 * PI) * 65536.0;
    return int'($floor(a + 0.5)) & 65535;
  endfunction

  function automatic int exp_mag(input int i, input int q);
`ifdef IQ_PHASE_DETECTOR_MAG_EN
    return int'($floor($sqrt(real'(i * i + q * q)) + 0.5));
`else
    return (i * 0) + (q * 0);
`endif
  endfunction

  task automatic check_eq(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_near(input string nm, input int act, input int exp, input int tol);
    int d;
    checks++;
    d = wdiff(act, exp);
    if (d > tol || d < -tol) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h +-%0d", nm, act, exp, tol);
    end
  endtask

  task automatic do_reset();
    sample_clk_ce = 1'b0;
    i_in = '0;
    q_in = '0;
    @(negedge clk);
    arst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic rand_iq(output int i, output int q);
    do begin
      i = int'($urandom_range(0, 127)) - 64;
      q = int'($urandom_range(0, 127)) - 64;
    end while (!((i >= 48) || (i <= -48) || (q >= 48) || (q <= -48)));
  endtask

  // One strobe, then wait (bounded) for out_valid; lat = clocks from accepting edge to update edge.
  task automatic do_sample(input int i, input int q, output int ph, output int fr,
                           output int mg, output int lat, output int ov_after);
    @(negedge clk);
    i_in = 7'(i);
    q_in = 7'(q);
    sample_clk_ce = 1'b1;
    @(negedge clk);
    sample_clk_ce = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    ph = int'(phase);
    fr = int'(freq);
    mg = int'(magnitude);
    @(negedge clk);
    ov_after = int'(out_valid);
  endtask

  // Strobes at the cycles listed in sched; the model accepts a strobe only when the
  // previous accepted one is at least 14 clocks earlier, others set the sticky overrun.
  task automatic run_schedule(input string nm);
    int exp_cyc[$];
    int exp_ph[$];
    int last_acc;
    int si;
    int n_acc;
    int n_ov;
    int exp_ovr;
    int total;
    int i;
    int q;
    do_reset();
    last_acc = -1000;
    si = 0;
    n_acc = 0;
    n_ov = 0;
    exp_ovr = 0;
    total = sched[sched.size() - 1] + 30;
    for (int c = 0; c < total; c++) begin
      @(negedge clk);
      check_eq({nm, "_overrun"}, int'(overrun), exp_ovr);
      if (out_valid) begin
        n_ov++;
        if (exp_cyc.size() == 0) begin
          check_eq({nm, "_unexpected_valid_cycle"}, c, -1);
        end else begin
          check_eq({nm, "_valid_cycle"}, c, exp_cyc[0]);
          check_near({nm, "_phase"}, int'(phase), exp_ph[0], 64);
          void'(exp_cyc.pop_front());
          void'(exp_ph.pop_front());
        end
      end else if (exp_cyc.size() != 0 && exp_cyc[0] == c) begin
        check_eq({nm, "_missing_valid_cycle"}, -1, c);
        void'(exp_cyc.pop_front());
        void'(exp_ph.pop_front());
      end
      sample_clk_ce = 1'b0;
      if (si < sched.size() && sched[si] == c) begin
        rand_iq(i, q);
        i_in = 7'(i);
        q_in = 7'(q);
        sample_clk_ce = 1'b1;
        si++;
        if (c - last_acc >= 14) begin
          last_acc = c;
          n_acc++;
          exp_cyc.push_back(c + 14);
          exp_ph.push_back(model_phase(i, q));
        end else begin
          exp_ovr = 1;
        end
      end
    end
    check_eq({nm, "_valid_count"}, n_ov, n_acc);
  endtask

  initial begin
    int ph, fr, mg, lat, ova;
    int mp, prev_mp;
    int i, q;
    int ov_seen;

    vecs[0] = '{63, 0, 16'h0000, 0};
    vecs[1] = '{0, 63, 16'h4000, 16'h4000};
    vecs[2] = '{-64, 0, 16'h8000, 16'h4000};
    vecs[3] = '{0, -64, 16'hC000, 16'h4000};
    vecs[4] = '{45, 45, 16'h2000, 16'h6000};
    vecs[5] = '{-45, 45, 16'h6000, 16'h4000};
    vecs[6] = '{-45, -45, 16'hA000, 16'h4000};
    vecs[7] = '{45, -45, 16'hE000, 16'h4000};

    repeat (2) @(negedge clk);
    arst = 1'b0;
    @(negedge clk);
    check_eq("reset_phase", int'(phase), 0);
    check_eq("reset_freq", int'(freq), 0);
    check_eq("reset_magnitude", int'(magnitude), 0);
    check_eq("reset_out_valid", int'(out_valid), 0);
    check_eq("reset_busy", int'(busy), 0);
    check_eq("reset_overrun", int'(overrun), 0);

    // Cardinal and diagonal vectors.
    for (int n = 0; n < 8; n++) begin
      do_sample(vecs[n].i, vecs[n].q, ph, fr, mg, lat, ova);
      check_eq($sformatf("vec%0d_latency", n), lat, 13);
      check_eq($sformatf("vec%0d_pulse_width", n), ova, 0);
      check_near($sformatf("vec%0d_phase", n), ph, vecs[n].exp_phase, 64);
      if (n == 0) check_eq("vec0_first_freq", fr, 0);
      else check_near($sformatf("vec%0d_freq", n), fr, vecs[n].exp_freq, 128);
      check_near($sformatf("vec%0d_magnitude", n), mg, exp_mag(vecs[n].i, vecs[n].q), MAG_TOL);
    end

    // Zero sample after (0,63): phase holds, freq/magnitude zero, reference unchanged.
    do_sample(0, 63, ph, fr, mg, lat, ova);
    do_sample(0, 0, ph, fr, mg, lat, ova);
    check_eq("zero_latency", lat, 13);
    check_near("zero_phase_hold", ph, 16'h4000, 64);
    check_eq("zero_freq", fr, 0);
    check_eq("zero_magnitude", mg, 0);
    do_sample(-64, 0, ph, fr, mg, lat, ova);
    check_near("after_zero_freq", fr, 16'h4000, 128);

    // NCO tone stepping 0x0400 per sample; wraps through 0xFFFF -> 0x0000 at n = 64.
    do_reset();
    prev_mp = 0;
    for (int n = 0; n < 70; n++) begin
      real ang;
      ang = 2.0 * PI * real'(n * 1024) / 65536.0;
      i = int'($floor(63.0 * $cos(ang) + 0.5));
      q = int'($floor(63.0 * $sin(ang) + 0.5));
      mp = model_phase(i, q);
      do_sample(i, q, ph, fr, mg, lat, ova);
      check_eq($sformatf("tone%0d_latency", n), lat, 13);
      check_near($sformatf("tone%0d_phase", n), ph, mp, 64);
      if (n == 0) check_eq("tone_first_freq", fr, 0);
      else check_near($sformatf("tone%0d_freq", n), fr, (mp - prev_mp) & 65535, 64);
      prev_mp = mp;
    end

    // Random vectors against atan2.
    for (int n = 0; n < 30; n++) begin
      rand_iq(i, q);
      mp = model_phase(i, q);
      do_sample(i, q, ph, fr, mg, lat, ova);
      check_near($sformatf("rand%0d_phase", n), ph, mp, 64);
      check_near($sformatf("rand%0d_freq", n), fr, (mp - prev_mp) & 65535, 96);
      check_near($sformatf("rand%0d_magnitude", n), mg, exp_mag(i, q), MAG_TOL);
      prev_mp = mp;
    end

    // Strobe spacing boundaries and overrun.
    sched.delete();
    for (int n = 0; n < 10; n++) sched.push_back(n * 5);
    run_schedule("every5");
    sched.delete();
    sched.push_back(0);
    sched.push_back(13);
    run_schedule("gap13");
    sched.delete();
    sched.push_back(0);
    sched.push_back(14);
    run_schedule("gap14");

    // Asynchronous reset in the middle of the iterations.
    do_reset();
    do_sample(0, 63, ph, fr, mg, lat, ova);
    do_sample(-64, 0, ph, fr, mg, lat, ova);
    @(negedge clk);
    i_in = 7'(45);
    q_in = 7'(45);
    sample_clk_ce = 1'b1;
    @(negedge clk);
    sample_clk_ce = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("arst_busy_before", int'(busy), 1);
    #2;
    arst = 1'b1;
    #1;
    check_eq("arst_phase", int'(phase), 0);
    check_eq("arst_freq", int'(freq), 0);
    check_eq("arst_magnitude", int'(magnitude), 0);
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_out_valid", int'(out_valid), 0);
    @(negedge clk);
    arst = 1'b0;
    ov_seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    check_eq("arst_no_valid", ov_seen, 0);
    do_sample(0, 63, ph, fr, mg, lat, ova);
    check_eq("arst_next_freq", fr, 0);
    check_near("arst_next_phase", ph, 16'h4000, 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
